// File: rtl/ac_control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mano_ac_pkg
// Brief   : Opcodes, FSM encoding and pulse-select helper for the AC sequencer.
// Revision: 1.0
// ============================================================================
package mano_ac_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OPC_W_DEF  = 4;

    localparam logic [OPC_W_DEF-1:0] OP_NOP = 4'd0;
    localparam logic [OPC_W_DEF-1:0] OP_AND = 4'd1;
    localparam logic [OPC_W_DEF-1:0] OP_ADD = 4'd2;
    localparam logic [OPC_W_DEF-1:0] OP_LDA = 4'd3;
    localparam logic [OPC_W_DEF-1:0] OP_CLA = 4'd4;
    localparam logic [OPC_W_DEF-1:0] OP_CMA = 4'd5;
    localparam logic [OPC_W_DEF-1:0] OP_CIR = 4'd6;
    localparam logic [OPC_W_DEF-1:0] OP_CIL = 4'd7;
    localparam logic [OPC_W_DEF-1:0] OP_CLE = 4'd8;
    localparam logic [OPC_W_DEF-1:0] OP_CME = 4'd9;

    // Bit positions inside the one-hot pulse vector
    localparam int PB_LD  = 0;
    localparam int PB_CLR = 1;
    localparam int PB_COM = 2;
    localparam int PB_CIR = 3;
    localparam int PB_CIL = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CAPT   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_PULSE  = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    function automatic logic [4:0] pulse_sel(input logic [OPC_W_DEF-1:0] op);
        logic [4:0] v;
        v = '0;
        case (op)
            OP_AND, OP_ADD, OP_LDA: v[PB_LD]  = 1'b1;
            OP_CLA:                 v[PB_CLR] = 1'b1;
            OP_CMA:                 v[PB_COM] = 1'b1;
            OP_CIR:                 v[PB_CIR] = 1'b1;
            OP_CIL:                 v[PB_CIL] = 1'b1;
            default:                v = '0;
        endcase
        return v;
    endfunction

    function automatic logic op_is_illegal(input logic [OPC_W_DEF-1:0] op);
        return (op > OP_CME);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ac_control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : ac_control_sequencer_if
// Brief   : Decoder-side handshake plus accumulator control bundle.
// Revision: 1.0
// ============================================================================
interface ac_control_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 4
) ();
    logic              instr_valid;
    logic              instr_ready;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] DR_data;
    logic [DATA_W-1:0] AC_in;
    logic [DATA_W-1:0] alu_out;
    logic              LD_load;
    logic              CLR_ac;
    logic              COM_complement;
    logic              CIR_circulateR;
    logic              CIL_circulateL;
    logic              E_flag;
    logic              done;
    logic              illegal;

    modport master (
        output instr_valid, opcode, DR_data, AC_in,
        input  instr_ready, alu_out, LD_load, CLR_ac, COM_complement,
               CIR_circulateR, CIL_circulateL, E_flag, done, illegal
    );

    modport slave (
        input  instr_valid, opcode, DR_data, AC_in,
        output instr_ready, alu_out, LD_load, CLR_ac, COM_complement,
               CIR_circulateR, CIL_circulateL, E_flag, done, illegal
    );
endinterface
`default_nettype wire

// File: rtl/ac_control_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module  : ac_alu_comb
// Brief   : Combinational AND/ADD/LDA load-value generator with carry out.
// Revision: 1.0
// ============================================================================
module ac_alu_comb
    import mano_ac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input  wire [OPC_W-1:0]  i_op,
    input  wire [DATA_W-1:0] i_ac,
    input  wire [DATA_W-1:0] i_dr,
    output logic [DATA_W-1:0] o_res,
    output logic              o_carry,
    output logic              o_ld
);
    logic [DATA_W:0] w_sum;

    always_comb begin
        w_sum   = {1'b0, i_ac} + {1'b0, i_dr};
        o_res   = '0;
        o_carry = 1'b0;
        o_ld    = 1'b0;
        case (i_op)
            OP_AND: begin
                o_res = i_ac & i_dr;
                o_ld  = 1'b1;
            end
            OP_ADD: begin
                o_res   = w_sum[DATA_W-1:0];
                o_carry = w_sum[DATA_W];
                o_ld    = 1'b1;
            end
            OP_LDA: begin
                o_res = i_dr;
                o_ld  = 1'b1;
            end
            default: begin
                o_ld = 1'b0;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/ac_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ac_control_sequencer
// Brief   : Five-state op sequencer issuing registered control pulses and E.
// Revision: 1.0
// ============================================================================
module ac_control_sequencer
    import mano_ac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input  wire                   CLK,
    input  wire                   CLR_clear,
    ac_control_sequencer_if.slave bus
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_pulse;
    logic [4:0]        w_pulse_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_illegal;
    logic              w_illegal_nxt;
    logic              r_e;
    logic              w_e_nxt;
    logic [OPC_W-1:0]  r_op;
    logic [DATA_W-1:0] r_alu;
    logic              r_carry;
    logic              r_ac_lsb;
    logic              r_ac_msb;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_carry;
    logic              w_alu_ld;

    // ALU sees the live operands during CAPT so alu_out is ready one cycle ahead of LD_load
    ac_alu_comb #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W)
    ) u_alu (
        .i_op    (r_op),
        .i_ac    (bus.AC_in),
        .i_dr    (bus.DR_data),
        .o_res   (w_alu_res),
        .o_carry (w_alu_carry),
        .o_ld    (w_alu_ld)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_pulse_nxt   = '0;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        w_e_nxt       = r_e;
        case (r_state)
            ST_IDLE: begin
                if (bus.instr_valid) w_state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = ST_PULSE;
                w_pulse_nxt = pulse_sel(r_op);
                case (r_op)
                    OP_ADD:  w_e_nxt = r_carry;
                    OP_CIR:  w_e_nxt = r_ac_lsb;
                    OP_CIL:  w_e_nxt = r_ac_msb;
                    OP_CLE:  w_e_nxt = 1'b0;
                    OP_CME:  w_e_nxt = ~r_e;
                    default: w_e_nxt = r_e;
                endcase
            end
            ST_PULSE: begin
                w_state_nxt   = ST_SETTLE;
                w_done_nxt    = 1'b1;
                w_illegal_nxt = op_is_illegal(r_op);
            end
            ST_SETTLE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR_clear) begin
        if (CLR_clear) begin
            r_state   <= ST_IDLE;
            r_pulse   <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_e       <= 1'b0;
            r_op      <= '0;
            r_alu     <= '0;
            r_carry   <= 1'b0;
            r_ac_lsb  <= 1'b0;
            r_ac_msb  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pulse   <= w_pulse_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
            r_e       <= w_e_nxt;
            if (r_state == ST_IDLE && bus.instr_valid) begin
                r_op <= bus.opcode;
            end
            if (r_state == ST_CAPT) begin
                r_ac_lsb <= bus.AC_in[0];
                r_ac_msb <= bus.AC_in[DATA_W-1];
                r_carry  <= w_alu_carry;
                if (w_alu_ld) r_alu <= w_alu_res;
            end
        end
    end

    assign bus.instr_ready    = (r_state == ST_IDLE) && !CLR_clear;
    assign bus.alu_out        = r_alu;
    assign bus.LD_load        = r_pulse[PB_LD];
    assign bus.CLR_ac         = r_pulse[PB_CLR];
    assign bus.COM_complement = r_pulse[PB_COM];
    assign bus.CIR_circulateR = r_pulse[PB_CIR];
    assign bus.CIL_circulateL = r_pulse[PB_CIL];
    assign bus.E_flag         = r_e;
    assign bus.done           = r_done;
    assign bus.illegal        = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ac_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ac_control_sequencer
// Brief   : Randomized and directed bench with a transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_ac_control_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ac_control_sequencer_if #(.DATA_W(8), .OPC_W(4)) bus ();

    ac_control_sequencer #(.DATA_W(8), .OPC_W(4)) dut (
        .CLK       (clk),
        .CLR_clear (rst),
        .bus       (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] exp_pulse(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd3: return 5'b00001;
            4'd4:             return 5'b00010;
            4'd5:             return 5'b00100;
            4'd6:             return 5'b01000;
            4'd7:             return 5'b10000;
            default:          return 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] act_pulse();
        return {bus.CIL_circulateL, bus.CIR_circulateR, bus.COM_complement, bus.CLR_ac, bus.LD_load};
    endfunction

    // Reference model: an op occupies five edges after its transfer; age counts edges since transfer
    bit         m_busy = 1'b0;
    int         m_age  = 0;
    logic [3:0] m_op   = 4'd0;
    logic [7:0] m_ac   = 8'd0;
    logic [7:0] m_dr   = 8'd0;
    logic [7:0] m_alu  = 8'd0;
    logic       m_e    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_alu  = 8'd0;
            m_e    = 1'b0;
        end else if (m_busy) begin
            m_age++;
            if (m_age == 1) begin
                m_ac = bus.AC_in;
                m_dr = bus.DR_data;
                case (m_op)
                    4'd1:    m_alu = m_ac & m_dr;
                    4'd2:    m_alu = 8'((int'(m_ac) + int'(m_dr)) % 256);
                    4'd3:    m_alu = m_dr;
                    default: ;
                endcase
            end else if (m_age == 2) begin
                case (m_op)
                    4'd2:    m_e = (int'(m_ac) + int'(m_dr)) > 255;
                    4'd6:    m_e = m_ac[0];
                    4'd7:    m_e = m_ac[7];
                    4'd8:    m_e = 1'b0;
                    4'd9:    m_e = ~m_e;
                    default: ;
                endcase
            end else if (m_age == 4) begin
                m_busy = 1'b0;
            end
        end else if (bus.instr_valid) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_op   = bus.opcode;
        end
    end

    logic [4:0] prev_pulse = 5'd0;

    always @(negedge clk) begin
        logic [4:0] ep;
        logic       ed;
        ep = (!rst && m_busy && m_age == 2) ? exp_pulse(m_op) : 5'd0;
        ed = !rst && m_busy && m_age == 3;
        chk("ready",    32'(bus.instr_ready), 32'(!rst && !m_busy));
        chk("pulses",   32'(act_pulse()),     32'(ep));
        chk("done",     32'(bus.done),        32'(ed));
        chk("illegal",  32'(bus.illegal),     32'(ed && m_op > 4'd9));
        chk("alu_out",  32'(bus.alu_out),     32'(m_alu));
        chk("e_flag",   32'(bus.E_flag),      32'(m_e));
        chk("onehot0",  32'($onehot0(act_pulse())), 32'd1);
        chk("pulse_1cy", 32'(act_pulse() & prev_pulse), 32'd0);
        prev_pulse = act_pulse();
    end

    task automatic do_op(input logic [3:0] op, input logic [7:0] ac, input logic [7:0] dr,
                         input bit junk, output logic [4:0] seen, output logic ill, output int lat);
        int k;
        seen = '0;
        ill  = 1'b0;
        k    = 0;
        @(negedge clk); #1;
        while (bus.instr_ready !== 1'b1 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 20) chk("ready_timeout", 32'd0, 32'd1);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.AC_in       = ac;
        bus.DR_data     = dr;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        if (junk) begin
            bus.AC_in       = 8'($urandom);
            bus.DR_data     = 8'($urandom);
            bus.opcode      = 4'($urandom);
            bus.instr_valid = 1'($urandom_range(0, 1));
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
            seen |= act_pulse();
        end while (bus.done !== 1'b1 && k < 10);
        if (bus.done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
        ill = bus.illegal;
        lat = k + 1;
        #1 bus.instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] seen;
        logic       ill;
        int         lat;
        int         k;
        int         c;
        int         dt[$];

        bus.instr_valid = 1'b0;
        bus.opcode      = 4'd0;
        bus.AC_in       = 8'd0;
        bus.DR_data     = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_alu",   32'(bus.alu_out),     32'd0);
        chk("rst_e",     32'(bus.E_flag),      32'd0);
        #1 rst = 1'b0;

        do_op(4'd2, 8'hF0, 8'h20, 1'b0, seen, ill, lat);
        chk("add_alu", 32'(bus.alu_out), 32'h10);
        chk("add_e",   32'(bus.E_flag),  32'd1);
        chk("add_pulse", 32'(seen), 32'b00001);
        chk("add_latency", 32'(lat), 32'd4);

        do_op(4'd1, 8'h98, 8'h0F, 1'b0, seen, ill, lat);
        chk("and_alu", 32'(bus.alu_out), 32'h08);
        chk("and_e",   32'(bus.E_flag),  32'd1);

        do_op(4'd3, 8'h00, 8'h5A, 1'b1, seen, ill, lat);
        chk("lda_alu", 32'(bus.alu_out), 32'h5A);

        do_op(4'd6, 8'h99, 8'h00, 1'b0, seen, ill, lat);
        chk("cir_pulse", 32'(seen), 32'b01000);
        chk("cir_e",     32'(bus.E_flag), 32'd1);
        chk("cir_alu_hold", 32'(bus.alu_out), 32'h5A);

        do_op(4'd7, 8'h7F, 8'h00, 1'b0, seen, ill, lat);
        chk("cil_pulse", 32'(seen), 32'b10000);
        chk("cil_e",     32'(bus.E_flag), 32'd0);

        do_op(4'd9, 8'h00, 8'h00, 1'b0, seen, ill, lat);
        chk("cme1_e", 32'(bus.E_flag), 32'd1);
        do_op(4'd9, 8'h00, 8'h00, 1'b0, seen, ill, lat);
        chk("cme2_e", 32'(bus.E_flag), 32'd0);

        do_op(4'hC, 8'h12, 8'h34, 1'b0, seen, ill, lat);
        chk("illegal_nopulse", 32'(seen), 32'd0);
        chk("illegal_strobe",  32'(ill),  32'd1);
        chk("illegal_latency", 32'(lat),  32'd4);

        // Valid held high: transfers should be exactly five cycles apart
        @(negedge clk); #1;
        bus.instr_valid = 1'b1;
        bus.opcode      = 4'd9;
        c = 0;
        repeat (24) begin
            @(negedge clk);
            c++;
            if (bus.done === 1'b1) dt.push_back(c);
        end
        #1 bus.instr_valid = 1'b0;
        chk("b2b_count", 32'(dt.size() >= 4), 32'd1);
        for (int i = 1; i < dt.size(); i++) chk("b2b_spacing", 32'(dt[i] - dt[i-1]), 32'd5);

        // Reset in the middle of an LDA load pulse, with E previously set
        do_op(4'd2, 8'hFF, 8'h01, 1'b0, seen, ill, lat);
        chk("pre_rst_e", 32'(bus.E_flag), 32'd1);
        k = 0;
        @(negedge clk); #1;
        while (bus.instr_ready !== 1'b1 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        bus.instr_valid = 1'b1;
        bus.opcode      = 4'd3;
        bus.DR_data     = 8'hA5;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.LD_load !== 1'b1 && k < 10);
        chk("rst_lda_pulse_seen", 32'(bus.LD_load), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ld",    32'(bus.LD_load),     32'd0);
        chk("rst_mid_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_mid_alu",   32'(bus.alu_out),     32'd0);
        chk("rst_mid_e",     32'(bus.E_flag),      32'd0);
        chk("rst_mid_done",  32'(bus.done),        32'd0);
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_idle_ready", 32'(bus.instr_ready), 32'd1);

        for (int i = 0; i < 60; i++) begin
            do_op(4'($urandom), 8'($urandom), 8'($urandom), 1'b1, seen, ill, lat);
            chk("rand_latency", 32'(lat), 32'd4);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
